// File: rtl/rom_reader.sv
// rom_reader: streams a burst of ROM words out over a valid/ready interface.
// Latency: first address the cycle after start, first out_valid one cycle after that, then one word per cycle.
// Backpressure: a read is issued only while FIFO count plus in-flight reads is below FIFO_DEPTH.
// Optional checksum output enabled by defining ROM_READER_CHECKSUM_EN.

// rom_reader_fifo: power-of-two circular buffer with a count.
// Latency: a pushed word is visible at the head on the next cycle.
// Backpressure: a push into a full buffer is dropped unless a pop happens in the same cycle.
module rom_reader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic                     head_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   ONE_CNT  = (PW+1)'(1);
    localparam logic [PW-1:0] ONE_PTR  = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign head_vld = (count != '0);
    assign pop      = head_vld && pop_rdy;
    assign push     = push_vld && ((count != FULL_CNT) || pop);
    // Empty head reads as zero so the stream data is clean after reset.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE_PTR;
            if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

// rom_reader top: IDLE/ISSUE/DRAIN burst controller around a latency-1 ROM.
// Latency: start -> address 1 cycle, -> out_valid 2 cycles; done in the cycle after the last word is taken.
// Backpressure: out_ready stalls the head; reads pause when the buffer plus in-flight read is full.
module rom_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock0,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
`ifdef ROM_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CW:0]           OCC_MAX  = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH:0]   remain_q;
    logic [ADDR_WIDTH:0]   remain_d;
    logic                  inflight_q;
    logic                  zero_done_q;
    logic                  issue;
    logic                  zero_start;
    logic                  drain_done;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           occupancy;
    logic                  room;

    // The ROM answers one cycle after the address register changes, so an
    // in-flight read always lands in the buffer on the following edge.
    rom_reader_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clock0),
        .rst      (reset),
        .push_vld (inflight_q),
        .push_dat (data),
        .pop_rdy  (out_ready),
        .head_vld (out_valid),
        .head_dat (out_data),
        .count    (fifo_count)
    );

    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign room      = (occupancy < OCC_MAX);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        issue      = 1'b0;
        zero_start = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            IDLE: begin
                // The first address goes out on the accepting edge itself.
                if (start) begin
                    if (length != '0) begin
                        state_d  = ISSUE;
                        issue    = 1'b1;
                        addr_d   = base_addr;
                        remain_d = length - LEN_ONE;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (remain_q == '0) begin
                    state_d = DRAIN;
                end else if (room) begin
                    issue    = 1'b1;
                    addr_d   = addr_q + ADDR_ONE;
                    remain_d = remain_q - LEN_ONE;
                end
            end
            DRAIN: begin
                if ((fifo_count == '0) && !inflight_q) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            inflight_q  <= issue;
            zero_done_q <= zero_start;
        end
    end

    assign address = addr_q;
    assign done    = drain_done || zero_done_q;
    assign busy    = (state_q != IDLE) && !drain_done;

`ifdef ROM_READER_CHECKSUM_EN
    // Start and output pops never coincide: the buffer is empty in IDLE.
    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if ((state_q == IDLE) && start) begin
            checksum <= '0;
        end else if (out_valid && out_ready) begin
            checksum <= checksum + out_data;
        end
    end
`endif
endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: burst table plus reset and re-start sequences, scoreboarded output stream.
module tb_rom_reader;
    logic       clock0 = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic [6:0] base_addr = '0;
    logic [7:0] length = '0;
    logic [6:0] address;
    logic [7:0] data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
`ifdef ROM_READER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    rom_reader #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (7),
        .FIFO_DEPTH (4)
    ) dut (
        .clock0    (clock0),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .address   (address),
        .data      (data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef ROM_READER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clock0 = ~clock0;

    // ROM contents; data follows the registered address, landing before the next edge.
    logic [7:0] rom [128];
    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'(i) ^ 8'hA5;
    end
    assign data = rom[address];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer: 0 = always ready, 1 = ready one cycle in three, 2 = random.
    int ready_mode = 0;
    int rcyc = 0;
    always @(posedge clock0) begin
        #1;
        rcyc++;
        case (ready_mode)
            1:       out_ready = (rcyc % 3 == 0);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // Scoreboard and stream monitor.
    logic [7:0] exp_q[$];
    int   done_cnt = 0;
    int   acc_cnt  = 0;
    bit   busy_seen = 0;
    bit   valid_seen = 0;
    bit   stall_prev = 0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_word;

    always @(negedge clock0) begin
        if (reset) begin
            stall_prev = 0;
        end else begin
            if (done) done_cnt++;
            if (busy) busy_seen = 1;
            if (out_valid) valid_seen = 1;
            if (stall_prev) begin
                check("stall_valid_held", int'(out_valid), 1);
                check("stall_data_held", int'(out_data), int'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", int'(out_data), -1);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("word", int'(out_data), int'(exp_word));
                    acc_cnt++;
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic pulse_start(input int b, input int l);
        @(posedge clock0); #1;
        start = 1'b1; base_addr = 7'(b); length = 8'(l);
        @(posedge clock0); #1;
        start = 1'b0; base_addr = 7'($urandom); length = 8'($urandom);
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clock0);
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        int exp_words;
        int exp_lat;
    } vec_t;

    task automatic run_burst(input vec_t v);
        int d0, a0, cyc;
        logic [7:0] sum;
        sum = '0;
        for (int i = 0; i < v.len; i++) begin
            exp_q.push_back(rom[(v.base + i) % 128]);
            sum = sum + rom[(v.base + i) % 128];
        end
        ready_mode = v.mode;
        busy_seen = 0; valid_seen = 0;
        d0 = done_cnt; a0 = acc_cnt;
        pulse_start(v.base, v.len);
`ifdef ROM_READER_CHECKSUM_EN
        check("checksum_cleared_on_start", int'(checksum), 0);
`endif
        wait_done(v.len * 6 + 20, cyc);
        check("done_seen", (cyc > 0) ? 1 : 0, 1);
        check("busy_low_with_done", int'(busy), 0);
        if (v.exp_lat >= 0) check("done_latency", cyc, v.exp_lat);
        repeat (3) @(negedge clock0);
        check("done_pulses", done_cnt - d0, 1);
        check("words_accepted", acc_cnt - a0, v.exp_words);
        check("scoreboard_empty", exp_q.size(), 0);
        check("busy_after", int'(busy), 0);
        if (v.len == 0) begin
            check("zero_len_busy_seen", int'(busy_seen), 0);
            check("zero_len_valid_seen", int'(valid_seen), 0);
        end
`ifdef ROM_READER_CHECKSUM_EN
        check("checksum_final", int'(checksum), int'(sum));
`endif
        exp_q.delete();
    endtask

    vec_t vecs[7];

    initial begin
        int d0, a0, cyc;
        vecs[0] = '{base:0,   len:128, mode:0, exp_words:128, exp_lat:130};
        vecs[1] = '{base:126, len:4,   mode:0, exp_words:4,   exp_lat:6};
        vecs[2] = '{base:5,   len:8,   mode:1, exp_words:8,   exp_lat:-1};
        vecs[3] = '{base:40,  len:0,   mode:0, exp_words:0,   exp_lat:1};
        vecs[4] = '{base:100, len:1,   mode:0, exp_words:1,   exp_lat:3};
        vecs[5] = '{base:64,  len:16,  mode:2, exp_words:16,  exp_lat:-1};
        vecs[6] = '{base:120, len:12,  mode:1, exp_words:12,  exp_lat:-1};

        // Reset values, held in reset and just after release.
        repeat (3) @(posedge clock0);
        #2;
        check("rst_address", int'(address), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_data", int'(out_data), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock0);
        check("idle_busy", int'(busy), 0);
        check("idle_valid", int'(out_valid), 0);
`ifdef ROM_READER_CHECKSUM_EN
        check("rst_checksum", int'(checksum), 0);
`endif

        for (int i = 0; i < 7; i++) run_burst(vecs[i]);

        // A second start in mid-burst must be ignored.
        ready_mode = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back(rom[20 + i]);
        d0 = done_cnt; a0 = acc_cnt;
        pulse_start(20, 6);
        @(posedge clock0); #1;
        start = 1'b1; base_addr = 7'd50; length = 8'd3;
        @(posedge clock0); #1;
        start = 1'b0;
        wait_done(60, cyc);
        check("restart_done_seen", (cyc > 0) ? 1 : 0, 1);
        repeat (4) @(negedge clock0);
        check("restart_words", acc_cnt - a0, 6);
        check("restart_done_pulses", done_cnt - d0, 1);
        check("restart_scoreboard_empty", exp_q.size(), 0);
        exp_q.delete();

        // Reset in mid-burst after three accepted words.
        ready_mode = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(rom[i]);
        a0 = acc_cnt;
        pulse_start(0, 8);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock0);
            if (acc_cnt - a0 >= 3) break;
        end
        check("midburst_three_words", acc_cnt - a0, 3);
        @(posedge clock0); #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_address", int'(address), 0);
        check("midrst_out_data", int'(out_data), 0);
`ifdef ROM_READER_CHECKSUM_EN
        check("midrst_checksum", int'(checksum), 0);
`endif
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clock0);
        #1;
        reset = 1'b0;
        valid_seen = 0; busy_seen = 0;
        repeat (5) @(negedge clock0);
        check("no_done_after_reset", done_cnt - d0, 0);
        check("no_valid_after_reset", int'(valid_seen), 0);
        check("no_busy_after_reset", int'(busy_seen), 0);
        run_burst('{base:10, len:2, mode:0, exp_words:2, exp_lat:4});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
